ram_store_arbiter: RTL and testbench
====================================

// Module: ram_store_arbiter
// PURPOSE
//  Shares the single 8-bit RAM write port between two store requesters (0: CPU execute stage, 1: debug/loader).
//  Arbitrates round-robin, latches one store of 1/2/4/8 bytes, serialises it little-endian one byte per cycle
//  at incrementing addresses, and signals completion. Sits between the requesters and the RAM write port.
// PARAMETERS
//  ADDR_W     16  RAM byte-address width; address arithmetic wraps modulo 2**ADDR_W
//  PRIO_RESET 0   requester holding round-robin priority after reset (0 or 1)
// PORTS
//  clk       in   1       single clock, all state updates on posedge
//  rst_n     in   1       synchronous, active-low reset
//  req0      in   1       requester 0 store request; held high until gnt0
//  size0     in   2       00=1B, 01=2B, 10=4B, 11=8B
//  addr0     in   ADDR_W  first byte address
//  data0     in   64      store data, byte k = data0[8k+7:8k]
//  gnt0      out  1       one-cycle pulse: request 0 accepted
//  done0     out  1       one-cycle pulse, coincident with last byte of a store for requester 0
//  err0      out  1       one-cycle pulse: request 0 rejected (see CONFIGURATION)
//  req1,size1,addr1,data1,gnt1,done1,err1   same as above for requester 1
//  ram_we    out  1       RAM byte write enable
//  ram_addr  out  ADDR_W  RAM byte address
//  ram_d     out  8       RAM write data
//  busy      out  1       high while a store is being serialised
// BEHAVIOUR
//  - Reset (rst_n low at an edge): state=IDLE, cnt=0, prio=PRIO_RESET; all outputs 0. An in-flight store is
//    aborted: no further bytes, no done pulse. ram_we is low from the first cycle after the reset edge.
//  - All outputs are registered. States: IDLE, WRITE.
//  - IDLE: at an edge with req0|req1 high, pick winner: if only one requests, that one; if both, the one
//    named by prio. Latch size/addr/data of winner, set prio to the other requester, go to WRITE.
//    Outputs for the following cycle: gntX=1, ram_we=1, ram_addr=addrX, ram_d=dataX[7:0], busy=1.
//  - WRITE, byte k (k=1..N-1, N=1,2,4,8): cycle k after acceptance drives ram_we=1, ram_addr=addr+k
//    (mod 2**ADDR_W, e.g. 0xFFFF+1=0x0000), ram_d=data[8k+7:8k]. cnt is 3 bits, 0..N-1.
//  - doneX=1 in the cycle that carries byte N-1 (for N=1, same cycle as gntX). At that edge state returns to
//    IDLE; ram_we, busy, done drop next cycle. Next acceptance occurs at the following edge, so there is
//    exactly one idle bubble cycle between back-to-back stores. Store latency: N cycles of writes + 1 bubble.
//  - Requests arriving while not in IDLE are not sampled; they wait. Request fields are sampled only at the
//    accepting edge; changes afterwards have no effect. Deasserting req before gnt withdraws it silently.
//  - Simultaneous req0 and req1 persistently: grants alternate 0,1,0,1,... (starvation-free).
//  - gnt, done, err are never high for both requesters in the same cycle.
// CONFIGURATION
//  STORE_ALIGN_CHK_EN defined: at the accepting edge, if addrX is not a multiple of N (N=2: addr[0]!=0;
//    N=4: addr[1:0]!=0; N=8: addr[2:0]!=0) the request is rejected: next cycle gntX=1 and errX=1,
//    ram_we=0, busy=0, no done; state stays IDLE; prio still rotates. 1-byte stores never fail.
//  STORE_ALIGN_CHK_EN undefined: no check, any address accepted, err0/err1 tied 0.
// TESTING
//  1. Reset: rst_n=0 for 2 cycles with req0=1 -> all outputs 0, no gnt; release -> gnt0 next cycle.
//  2. req0, size=11, addr=0x1000, data=0x8877665544332211 -> gnt0 cycle1; ram_we 8 cycles, addr 0x1000..0x1007,
//     ram_d 11,22,..,88; done0 with byte 0x88; ram_we=0 one cycle after.
//  3. req0 and req1 both held, size=00, PRIO_RESET=0 -> grants 0,1,0,1 each 2 cycles apart, never overlapping.
//  4. req1, size=10, addr=0xFFFE, data=0x0000_0000_DDCC_BBAA (macro off) -> writes AA@FFFE, BB@FFFF, CC@0000,
//     DD@0001; done1 with DD.
//  5. rst_n=0 during byte 3 of an 8-byte store -> ram_we low next cycle, no done; next req granted normally.
//  6. Macro on: req0, size=01, addr=0x0101 -> gnt0 and err0 pulse together, ram_we stays 0, busy stays 0.

Source files
------------

// File: rtl/ram_store_arbiter.sv
// Round-robin arbiter sharing one 8-bit RAM write port between two store requesters.
// A granted store of 1/2/4/8 bytes is serialised little-endian, one byte per cycle.
// Optional feature: define STORE_ALIGN_CHK_EN to reject stores whose address is not
// a multiple of the store size (gnt and err pulse together, nothing is written).
module ram_store_arbiter #(
   parameter int unsigned ADDR_W     = 16,
   parameter bit          PRIO_RESET = 1'b0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0,
   input  logic [1:0]        size0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [63:0]       data0,
   output logic              gnt0,
   output logic              done0,
   output logic              err0,
   input  logic              req1,
   input  logic [1:0]        size1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [63:0]       data1,
   output logic              gnt1,
   output logic              done1,
   output logic              err1,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [7:0]        ram_d,
   output logic              busy
);

   typedef enum logic {StIdle, StWrite} state_e;

   state_e            state_q, state_d;
   logic [2:0]        cnt_q, cnt_d;
   logic              prio_q, prio_d;
   logic              owner_q, owner_d;
   logic [1:0]        size_q, size_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [63:0]       data_q, data_d;

   logic [1:0]        gnt_q, gnt_d, done_q, done_d, err_q, err_d;
   logic              we_q, we_d, busy_q, busy_d;
   logic [ADDR_W-1:0] waddr_q, waddr_d;
   logic [7:0]        wdata_q, wdata_d;

   logic              any_req, win, reject, last_byte;
   logic [1:0]        win_size;
   logic [ADDR_W-1:0] win_addr;
   logic [63:0]       win_data;
   logic [2:0]        next_idx;

   // Index of the final byte for an encoded store size.
   function automatic logic [2:0] last_idx(input logic [1:0] sz);
      unique case (sz)
         2'b00:   last_idx = 3'd0;
         2'b01:   last_idx = 3'd1;
         2'b10:   last_idx = 3'd3;
         default: last_idx = 3'd7;
      endcase
   endfunction

   // Winner selection: a lone requester wins, otherwise the one holding priority.
   always_comb begin
      any_req   = req0 | req1;
      win       = (req0 & req1) ? prio_q : req1;
      win_size  = win ? size1 : size0;
      win_addr  = win ? addr1 : addr0;
      win_data  = win ? data1 : data0;
      last_byte = (cnt_q == last_idx(size_q));
      next_idx  = cnt_q + 3'd1;
   end

`ifdef STORE_ALIGN_CHK_EN
   // Misalignment check on the winning request; single bytes are always aligned.
   always_comb begin
      unique case (win_size)
         2'b00:   reject = 1'b0;
         2'b01:   reject = win_addr[0];
         2'b10:   reject = |win_addr[1:0];
         default: reject = |win_addr[2:0];
      endcase
   end
`else
   assign reject = 1'b0;
`endif

   // State and registered outputs, synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cnt_q   <= 3'd0;
         prio_q  <= PRIO_RESET;
         owner_q <= 1'b0;
         size_q  <= 2'b00;
         addr_q  <= '0;
         data_q  <= '0;
         gnt_q   <= 2'b00;
         done_q  <= 2'b00;
         err_q   <= 2'b00;
         we_q    <= 1'b0;
         busy_q  <= 1'b0;
         waddr_q <= '0;
         wdata_q <= 8'h00;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         prio_q  <= prio_d;
         owner_q <= owner_d;
         size_q  <= size_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         gnt_q   <= gnt_d;
         done_q  <= done_d;
         err_q   <= err_d;
         we_q    <= we_d;
         busy_q  <= busy_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
      end
   end

   // Next state: accept in IDLE, step through bytes in WRITE, return after the last one.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      prio_d  = prio_q;
      owner_d = owner_q;
      size_d  = size_q;
      addr_d  = addr_q;
      data_d  = data_q;
      unique case (state_q)
         StIdle: begin
            if (any_req) begin
               prio_d = ~win;
               if (!reject) begin
                  state_d = StWrite;
                  cnt_d   = 3'd0;
                  owner_d = win;
                  size_d  = win_size;
                  addr_d  = win_addr;
                  data_d  = win_data;
               end
            end
         end
         default: begin
            if (last_byte) begin
               state_d = StIdle;
               cnt_d   = 3'd0;
            end else begin
               cnt_d = next_idx;
            end
         end
      endcase
   end

   // Output values for the next cycle (byte 0 comes from the request, later bytes from the latch).
   always_comb begin
      gnt_d   = 2'b00;
      done_d  = 2'b00;
      err_d   = 2'b00;
      we_d    = 1'b0;
      busy_d  = 1'b0;
      waddr_d = '0;
      wdata_d = 8'h00;
      if (state_q == StIdle) begin
         if (any_req) begin
            gnt_d[win] = 1'b1;
            if (reject) begin
               err_d[win] = 1'b1;
            end else begin
               we_d         = 1'b1;
               busy_d       = 1'b1;
               waddr_d      = win_addr;
               wdata_d      = win_data[7:0];
               done_d[win]  = (win_size == 2'b00);
            end
         end
      end else if (!last_byte) begin
         we_d            = 1'b1;
         busy_d          = 1'b1;
         waddr_d         = addr_q + ADDR_W'(next_idx);
         wdata_d         = data_q[{next_idx, 3'b000} +: 8];
         done_d[owner_q] = (next_idx == last_idx(size_q));
      end
   end

   assign gnt0     = gnt_q[0];
   assign gnt1     = gnt_q[1];
   assign done0    = done_q[0];
   assign done1    = done_q[1];
   assign err0     = err_q[0];
   assign err1     = err_q[1];
   assign ram_we   = we_q;
   assign busy     = busy_q;
   assign ram_addr = waddr_q;
   assign ram_d    = wdata_q;

endmodule

// File: tb/tb_ram_store_arbiter.sv
// Self-checking bench for ram_store_arbiter: directed scenarios plus randomized traffic,
// checked every cycle against a queue-based transaction model.
module tb_ram_store_arbiter;

   localparam bit PRIO = 1'b0;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req0 = 1'b0, req1 = 1'b0;
   logic [1:0]  size0 = '0, size1 = '0;
   logic [15:0] addr0 = '0, addr1 = '0;
   logic [63:0] data0 = '0, data1 = '0;
   logic        gnt0, done0, err0, gnt1, done1, err1, ram_we, busy;
   logic [15:0] ram_addr;
   logic [7:0]  ram_d;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct packed {
      logic        gnt0, gnt1, done0, done1, err0, err1, we, busy;
      logic [15:0] addr;
      logic [7:0]  d;
   } out_t;

   out_t obs, exp_o;
   out_t mq[$];
   bit   m_prio = PRIO;

   assign obs = {gnt0, gnt1, done0, done1, err0, err1, ram_we, busy, ram_addr, ram_d};

   ram_store_arbiter #(.ADDR_W(16), .PRIO_RESET(PRIO)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .size0(size0), .addr0(addr0), .data0(data0),
      .gnt0(gnt0), .done0(done0), .err0(err0),
      .req1(req1), .size1(size1), .addr1(addr1), .data1(data1),
      .gnt1(gnt1), .done1(done1), .err1(err1),
      .ram_we(ram_we), .ram_addr(ram_addr), .ram_d(ram_d), .busy(busy)
   );

   always #5 clk = ~clk;

   // Advance one edge; the model reads the same inputs the DUT samples and queues
   // the whole per-cycle output sequence of an accepted store plus its idle bubble.
   task automatic tick();
      out_t        z, o;
      bit          w, bad;
      int          n;
      logic [1:0]  sz;
      logic [15:0] a;
      logic [63:0] dat;
      @(posedge clk);
      z = '0;
      if (!rst_n) begin
         mq.delete();
         m_prio = PRIO;
         exp_o  = z;
      end else if (mq.size() != 0) begin
         exp_o = mq.pop_front();
      end else if (req0 || req1) begin
         w      = (req0 && req1) ? m_prio : req1;
         m_prio = !w;
         sz     = w ? size1 : size0;
         a      = w ? addr1 : addr0;
         dat    = w ? data1 : data0;
         n      = 1 << sz;
         bad    = 1'b0;
`ifdef STORE_ALIGN_CHK_EN
         bad = ((a % n) != 0);
`endif
         if (bad) begin
            exp_o      = z;
            exp_o.gnt0 = !w;
            exp_o.gnt1 = w;
            exp_o.err0 = !w;
            exp_o.err1 = w;
         end else begin
            for (int k = 0; k < n; k++) begin
               o      = z;
               o.we   = 1'b1;
               o.busy = 1'b1;
               o.addr = a + 16'(k);
               o.d    = dat[8*k +: 8];
               if (k == 0) begin
                  o.gnt0 = !w;
                  o.gnt1 = w;
               end
               if (k == n - 1) begin
                  o.done0 = !w;
                  o.done1 = w;
               end
               mq.push_back(o);
            end
            mq.push_back(z);
            exp_o = mq.pop_front();
         end
      end else begin
         exp_o = z;
      end
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      req0  = 1'b1;
      size0 = 2'b00;
      addr0 = 16'h0040;
      data0 = 64'h5A;
      for (int c = 0; c < 2; c++) begin
         tick();
         n_tests++;
         if (obs !== '0 || exp_o !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs cyc %0d: got %h want 0", c, obs);
         end
      end
      rst_n = 1'b1;
      tick();
      n_tests++;
      if (gnt0 !== 1'b1 || obs !== exp_o) begin
         n_fail++;
         $display("FAIL reset_release_gnt0: got %h want %h", obs, exp_o);
      end
      req0 = 1'b0;
      for (int c = 0; c < 3; c++) begin
         tick();
         n_tests++;
         if (obs !== exp_o) begin
            n_fail++;
            $display("FAIL reset_drain cyc %0d: got %h want %h", c, obs, exp_o);
         end
      end
   endtask

   task automatic test_store8();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      req0  = 1'b1;
      size0 = 2'b11;
      addr0 = 16'h1000;
      data0 = 64'h8877665544332211;
      for (int k = 0; k < 8; k++) begin
         tick();
         if (k == 0) begin
            req0  = 1'b0;
            data0 = 64'hFFFF_FFFF_FFFF_FFFF;
            addr0 = 16'h7777;
         end
         n_tests++;
         if (obs !== exp_o || ram_we !== 1'b1 || ram_addr !== 16'h1000 + 16'(k)
             || ram_d !== 8'((k + 1) * 17) || done0 !== (k == 7) || gnt0 !== (k == 0)) begin
            n_fail++;
            $display("FAIL store8 byte %0d: got %h want %h", k, obs, exp_o);
         end
      end
      tick();
      n_tests++;
      if (ram_we !== 1'b0 || busy !== 1'b0 || done0 !== 1'b0 || obs !== exp_o) begin
         n_fail++;
         $display("FAIL store8_end: got %h want %h", obs, exp_o);
      end
   endtask

   task automatic test_alternate();
      bit want;
      int ngr;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      req0  = 1'b1;
      req1  = 1'b1;
      size0 = 2'b00;
      size1 = 2'b00;
      addr0 = 16'h2000;
      addr1 = 16'h3000;
      data0 = 64'hA0;
      data1 = 64'hB1;
      want  = PRIO;
      ngr   = 0;
      for (int c = 0; c < 12; c++) begin
         tick();
         n_tests++;
         if (obs !== exp_o) begin
            n_fail++;
            $display("FAIL alternate cyc %0d: got %h want %h", c, obs, exp_o);
         end
         if (gnt0 || gnt1) begin
            n_tests++;
            if ({gnt1, gnt0} !== (want ? 2'b10 : 2'b01)) begin
               n_fail++;
               $display("FAIL alternate_order cyc %0d: got %b want %b", c, {gnt1, gnt0},
                        want ? 2'b10 : 2'b01);
            end
            want = !want;
            ngr++;
         end
      end
      n_tests++;
      if (ngr !== 6) begin
         n_fail++;
         $display("FAIL alternate_count: got %0d want 6", ngr);
      end
      req0 = 1'b0;
      req1 = 1'b0;
   endtask

   task automatic test_wrap();
      logic [7:0] bytes [4];
      bytes = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      req1  = 1'b1;
      size1 = 2'b10;
      addr1 = 16'hFFFE;
      data1 = 64'h0000_0000_DDCC_BBAA;
      for (int k = 0; k < 5; k++) begin
         tick();
         req1 = 1'b0;
         n_tests++;
         if (obs !== exp_o) begin
            n_fail++;
            $display("FAIL wrap_model cyc %0d: got %h want %h", k, obs, exp_o);
         end
`ifndef STORE_ALIGN_CHK_EN
         if (k < 4) begin
            n_tests++;
            if (ram_we !== 1'b1 || ram_addr !== 16'hFFFE + 16'(k) || ram_d !== bytes[k]
                || done1 !== (k == 3)) begin
               n_fail++;
               $display("FAIL wrap_byte %0d: got %h@%h want %h@%h", k, ram_d, ram_addr,
                        bytes[k], 16'hFFFE + 16'(k));
            end
         end
`endif
      end
   endtask

   task automatic test_reset_midstore();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      req0  = 1'b1;
      size0 = 2'b11;
      addr0 = 16'h0500;
      data0 = 64'h0807060504030201;
      for (int k = 0; k < 4; k++) begin
         tick();
         req0 = 1'b0;
         n_tests++;
         if (obs !== exp_o) begin
            n_fail++;
            $display("FAIL midstore byte %0d: got %h want %h", k, obs, exp_o);
         end
      end
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      n_tests++;
      if (ram_we !== 1'b0 || done0 !== 1'b0 || obs !== exp_o) begin
         n_fail++;
         $display("FAIL midstore_abort: got %h want %h", obs, exp_o);
      end
      req1  = 1'b1;
      size1 = 2'b01;
      addr1 = 16'h0600;
      data1 = 64'h9F8E;
      for (int k = 0; k < 5; k++) begin
         tick();
         if (exp_o.gnt1) req1 = 1'b0;
         n_tests++;
         if (obs !== exp_o || done0 !== 1'b0) begin
            n_fail++;
            $display("FAIL midstore_next cyc %0d: got %h want %h", k, obs, exp_o);
         end
      end
   endtask

`ifdef STORE_ALIGN_CHK_EN
   task automatic test_misalign();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      req0  = 1'b1;
      size0 = 2'b01;
      addr0 = 16'h0101;
      tick();
      req0 = 1'b0;
      n_tests++;
      if (gnt0 !== 1'b1 || err0 !== 1'b1 || ram_we !== 1'b0 || busy !== 1'b0
          || obs !== exp_o) begin
         n_fail++;
         $display("FAIL misalign_reject: got %h want %h", obs, exp_o);
      end
      tick();
      n_tests++;
      if (obs !== '0 || obs !== exp_o) begin
         n_fail++;
         $display("FAIL misalign_after: got %h want 0", obs);
      end
   endtask
`endif

   task automatic test_random();
      logic [15:0] a;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      req0  = 1'b0;
      req1  = 1'b0;
      for (int c = 0; c < 800; c++) begin
         tick();
         n_tests++;
         if (obs !== exp_o) begin
            n_fail++;
            $display("FAIL random cyc %0d: got %h want %h", c, obs, exp_o);
         end
         if (exp_o.gnt0) begin
            req0  = 1'b0;
            addr0 = 16'($urandom);
            data0 = {$urandom, $urandom};
         end
         if (exp_o.gnt1) begin
            req1  = 1'b0;
            addr1 = 16'($urandom);
            data1 = {$urandom, $urandom};
         end
         if (!req0 && $urandom_range(0, 2) == 0) begin
            a = 16'($urandom);
            if ($urandom_range(0, 3) == 0) a = 16'hFFF8 | (a & 16'h0007);
            req0  = 1'b1;
            size0 = 2'($urandom);
            addr0 = a;
            data0 = {$urandom, $urandom};
         end else if (req0 && $urandom_range(0, 29) == 0) begin
            req0 = 1'b0;
         end
         if (!req1 && $urandom_range(0, 2) == 0) begin
            a = 16'($urandom);
            if ($urandom_range(0, 3) == 0) a = a & 16'hFFF8;
            req1  = 1'b1;
            size1 = 2'($urandom);
            addr1 = a;
            data1 = {$urandom, $urandom};
         end else if (req1 && $urandom_range(0, 29) == 0) begin
            req1 = 1'b0;
         end
         rst_n = ($urandom_range(0, 149) != 0);
      end
      rst_n = 1'b1;
      req0  = 1'b0;
      req1  = 1'b0;
   endtask

   initial begin
      test_reset();
      test_store8();
      test_alternate();
      test_wrap();
      test_reset_midstore();
`ifdef STORE_ALIGN_CHK_EN
      test_misalign();
`endif
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
